// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared encodings and helpers for the data memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size encodings as presented on the size port
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True when the access cannot be served: unaligned half/word or illegal size
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Brief    : Big-endian byte-lane steering. Store side builds byte enables
//            and the lane-shifted write word; load side extracts the lane,
//            right-justifies it and sign/zero extends.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext
);

  // Byte offset 0 is the most significant lane
  localparam logic [1:0] c_top_lane = 2'(WORD_BYTES - 1);

  logic [1:0]  w_lane;
  logic [4:0]  w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection for both directions; size decides which result is used
  always_comb begin
    w_lane    = c_top_lane - offset;
    w_shift   = {w_lane, 3'b000};
    w_byte    = 8'(rword >> w_shift);
    w_half    = offset[1] ? rword[15:0] : rword[31:16];
    byte_en   = 4'b0000;
    wword     = 32'h0000_0000;
    rdata_ext = 32'h0000_0000;
    case (size)
      SIZE_BYTE: begin
        byte_en   = 4'b0001 << w_lane;
        wword     = {24'h00_0000, wdata[7:0]} << w_shift;
        rdata_ext = {{24{sign_ext & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        byte_en   = offset[1] ? 4'b0011 : 4'b1100;
        wword     = offset[1] ? {16'h0000, wdata[15:0]} : {wdata[15:0], 16'h0000};
        rdata_ext = {{16{sign_ext & w_half[15]}}, w_half};
      end
      SIZE_WORD: begin
        byte_en   = 4'b1111;
        wword     = wdata;
        rdata_ext = rword;
      end
      default: begin
        byte_en   = 4'b0000;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Brief    : Byte-addressed data memory with big-endian lanes, extension,
//            misalignment detection and configurable wait states behind a
//            req/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic [31:0]           rdata,
  output logic                  err
);

  localparam int         DEPTH      = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);

  state_t r_state;
  state_t w_next;

  logic                  r_we;
  logic                  r_sign;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_bad;
  logic [3:0]            r_cnt;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_access;
  logic                  w_bad_in;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic [31:0]           w_word;
  logic [3:0]            w_be;
  logic [31:0]           w_wlane;
  logic [31:0]           w_load;
  logic [31:0]           w_merged;

  assign w_bad_in = is_misaligned(size, addr[1:0]);
  assign w_idx    = r_addr[ADDR_WIDTH-1:2];
  assign w_word   = r_mem[w_idx];
  assign rdata    = r_rdata;

  mem_lane_align u_lane_align (
    .size      (r_size),
    .offset    (r_addr[1:0]),
    .sign_ext  (r_sign),
    .wdata     (r_wdata),
    .rword     (w_word),
    .byte_en   (w_be),
    .wword     (w_wlane),
    .rdata_ext (w_load)
  );

  // Read-modify-write merge: enabled lanes take new data, others keep old
  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    assign w_merged[8*i +: 8] = w_be[i] ? w_wlane[8*i +: 8] : w_word[8*i +: 8];
  end

  // State register; asynchronous reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_access = 1'b0;
    ready    = 1'b0;
    err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          w_next   = w_bad_in ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        ready  = 1'b1;
        err    = r_bad;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request capture, wait countdown and load result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_size  <= SIZE_BYTE;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
      r_bad   <= 1'b0;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0000_0000;
    end else if (w_accept) begin
      r_we    <= we;
      r_sign  <= sign_ext;
      r_size  <= size;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_bad   <= w_bad_in;
      r_cnt   <= c_wait_init;
      if (w_bad_in && !we) begin
        r_rdata <= 32'h0000_0000;
      end
    end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end else if (w_access && !r_we) begin
      r_rdata <= w_load;
    end
  end

  // Storage array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_access && r_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Brief    : Directed self-checking bench; one instance with no wait states
//            and one with three wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        req0     = 1'b0;
  logic        req3     = 1'b0;
  logic        we       = 1'b0;
  logic [1:0]  size     = 2'b00;
  logic        sign_ext = 1'b0;
  logic [8:0]  addr     = 9'h000;
  logic [31:0] wdata    = 32'h0;
  logic        ready0, err0, ready3, err3;
  logic [31:0] rdata0, rdata3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .ready(ready0), .rdata(rdata0), .err(err0)
  );

  data_memory_ctrl #(.ADDR_WIDTH(9), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .ready(ready3), .rdata(rdata3), .err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, hold it until ready, then release and let DONE retire
  task automatic access(input bit sel3, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [8:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    if (sel3) req3 = 1'b1; else req0 = 1'b1;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (sel3 ? ready3 : ready0) break;
    end
    rd = sel3 ? rdata3 : rdata0;
    er = sel3 ? err3 : err0;
    req0 = 1'b0;
    req3 = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'b0, (sel3 ? ready3 : ready0)}, 32'd0);
  endtask

  task automatic op(input string tag, input bit sel3, input logic w, input logic [1:0] sz,
                    input logic sx, input logic [8:0] a, input logic [31:0] d,
                    input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(sel3, w, sz, sx, a, d, rd, er, lat);
    chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
    chk({tag, "_err"},   {31'b0, er}, {31'b0, exp_err});
    chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", {31'b0, ready0}, 32'd0);
    chk("rst_err0",   {31'b0, err0},   32'd0);
    chk("rst_rdata0", rdata0,          32'd0);
    chk("rst_ready3", {31'b0, ready3}, 32'd0);
    chk("rst_err3",   {31'b0, err3},   32'd0);
    chk("rst_rdata3", rdata3,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- zero wait states ----------------
    op("st_w010",   0, 1, 2'b10, 0, 9'h010, 32'hDEADBEEF, 2, 0, 32'h00000000);
    op("ld_w010",   0, 0, 2'b10, 0, 9'h010, 32'h0,        2, 0, 32'hDEADBEEF);
    op("st_b011",   0, 1, 2'b00, 0, 9'h011, 32'h00000055, 2, 0, 32'hDEADBEEF);
    op("ld_w010b",  0, 0, 2'b10, 0, 9'h010, 32'h0,        2, 0, 32'hDE55BEEF);
    op("ld_b010s",  0, 0, 2'b00, 1, 9'h010, 32'h0,        2, 0, 32'hFFFFFFDE);
    op("ld_b010z",  0, 0, 2'b00, 0, 9'h010, 32'h0,        2, 0, 32'h000000DE);
    op("ld_h012s",  0, 0, 2'b01, 1, 9'h012, 32'h0,        2, 0, 32'hFFFFBEEF);
    op("ld_h011",   0, 0, 2'b01, 1, 9'h011, 32'h0,        1, 1, 32'h00000000);
    op("ld_w010c",  0, 0, 2'b10, 0, 9'h010, 32'h0,        2, 0, 32'hDE55BEEF);
    op("ld_sz11",   0, 0, 2'b11, 0, 9'h010, 32'h0,        1, 1, 32'h00000000);
    op("ld_b013s",  0, 0, 2'b00, 1, 9'h013, 32'h0,        2, 0, 32'hFFFFFFEF);
    op("ld_h010z",  0, 0, 2'b01, 0, 9'h010, 32'h0,        2, 0, 32'h0000DE55);
    op("st_h012",   0, 1, 2'b01, 0, 9'h012, 32'h00001234, 2, 0, 32'h0000DE55);
    op("st_w012",   0, 1, 2'b10, 0, 9'h012, 32'h00000000, 1, 1, 32'h0000DE55);
    op("ld_w010d",  0, 0, 2'b10, 0, 9'h010, 32'h0,        2, 0, 32'hDE551234);
    op("ld_b012z",  0, 0, 2'b00, 0, 9'h012, 32'h0,        2, 0, 32'h00000012);
    op("st_w000",   0, 1, 2'b10, 0, 9'h000, 32'h11223344, 2, 0, 32'h00000012);
    op("st_w1fc",   0, 1, 2'b10, 0, 9'h1FC, 32'hCAFEF00D, 2, 0, 32'h00000012);
    op("ld_w000",   0, 0, 2'b10, 0, 9'h000, 32'h0,        2, 0, 32'h11223344);
    op("ld_w1fc",   0, 0, 2'b10, 0, 9'h1FC, 32'h0,        2, 0, 32'hCAFEF00D);
    op("ld_h1fes",  0, 0, 2'b01, 1, 9'h1FE, 32'h0,        2, 0, 32'hFFFFF00D);

    // ---------------- three wait states ----------------
    op("w3_ld_h021", 1, 0, 2'b01, 0, 9'h021, 32'h0,        1, 1, 32'h00000000);
    op("w3_st_w020", 1, 1, 2'b10, 0, 9'h020, 32'hA5A5A5A5, 5, 0, 32'h00000000);
    op("w3_ld_w020", 1, 0, 2'b10, 0, 9'h020, 32'h0,        5, 0, 32'hA5A5A5A5);

    // req toggling while busy is ignored; a req held through ready is served next
    @(negedge clk);
    we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 9'h020; req3 = 1'b1;
    @(posedge clk); #1;
    chk("tog_busy", {31'b0, ready3}, 32'd0);
    @(negedge clk); req3 = 1'b0; we = 1'b1; wdata = 32'h0;
    @(negedge clk); req3 = 1'b1;
    @(negedge clk); req3 = 1'b0;
    @(negedge clk); req3 = 1'b1; we = 1'b1; addr = 9'h024; wdata = 32'h0BADCAFE;
    @(posedge clk); #1;
    chk("tog_ready", {31'b0, ready3}, 32'd1);
    chk("tog_err",   {31'b0, err3},   32'd0);
    chk("tog_rdata", rdata3,          32'hA5A5A5A5);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (ready3) break;
    end
    chk("held_lat", 32'(lat), 32'd6);
    chk("held_err", {31'b0, err3}, 32'd0);
    req3 = 1'b0;
    @(posedge clk); #1;
    op("w3_ld_w024", 1, 0, 2'b10, 0, 9'h024, 32'h0, 5, 0, 32'h0BADCAFE);
    op("w3_ld_w020b", 1, 0, 2'b10, 0, 9'h020, 32'h0, 5, 0, 32'hA5A5A5A5);

    // reset during WAIT of a store aborts it without writing
    @(negedge clk);
    we = 1'b1; size = 2'b10; addr = 9'h020; wdata = 32'hFFFF0000; req3 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'b0, ready3}, 32'd0);
    chk("abort_err",   {31'b0, err3},   32'd0);
    chk("abort_rdata", rdata3,          32'd0);
    chk("abort_rdata0", rdata0,         32'd0);
    req3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op("w3_ld_w020c", 1, 0, 2'b10, 0, 9'h020, 32'h0, 5, 0, 32'hA5A5A5A5);
    op("ld_w010e",    0, 0, 2'b10, 0, 9'h010, 32'h0, 2, 0, 32'hDE551234);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
